// File: rtl/adat_rx_adat_pkg.sv
// Shared types for the ADAT receive path: sample-rate and lock-state enums,
// common field widths and the S/MUX2 rate-doubling helper.
package adat_rx_adat_pkg;

  localparam int unsigned FT_W        = 12;  // measured frame time width
  localparam int unsigned UB_W        = 4;   // user bits per frame
  localparam int unsigned CH_W        = 4;   // valid channel count width
  localparam int unsigned MISS_W      = 2;   // holdover miss counter width
  localparam int unsigned UB_SMUX_BIT = 1;   // user bit carrying S/MUX2

  typedef enum logic [2:0] {
    Rate44_1kHz,
    Rate48kHz,
    Rate88_2kHz,
    Rate96kHz,
    Unknown
  } SampleRate;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED,
    HOLDOVER
  } LockState;

  // S/MUX2 carries two samples per frame slot, doubling the base rate.
  function automatic SampleRate rate_for_mode(input SampleRate base_rate, input logic smux);
    SampleRate r;
    r = base_rate;
    if (smux) begin
      case (base_rate)
        Rate48kHz:   r = Rate96kHz;
        Rate44_1kHz: r = Rate88_2kHz;
        default:     r = base_rate;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/adat_rx_lock_controller_if.sv
// Frame-decoder-to-lock-controller bundle.
//   i_frame_time/i_frame_done/i_sync/i_user_bits : per-frame info from the decoder
//   o_locked/o_sample_rate/o_smux/o_valid_channels/o_state/o_miss_count : lock status
// master = decoder side (drives frame info), slave = lock controller.
interface adat_rx_lock_controller_if;
  import adat_rx_adat_pkg::*;

  logic [FT_W-1:0]   i_frame_time;
  logic              i_frame_done;
  logic              i_sync;
  logic [UB_W-1:0]   i_user_bits;

  logic              o_locked;
  SampleRate         o_sample_rate;
  logic              o_smux;
  logic [CH_W-1:0]   o_valid_channels;
  LockState          o_state;
  logic [MISS_W-1:0] o_miss_count;

  modport master (
    output i_frame_time, i_frame_done, i_sync, i_user_bits,
    input  o_locked, o_sample_rate, o_smux, o_valid_channels, o_state, o_miss_count
  );

  modport slave (
    input  i_frame_time, i_frame_done, i_sync, i_user_bits,
    output o_locked, o_sample_rate, o_smux, o_valid_channels, o_state, o_miss_count
  );
endinterface

// File: rtl/adat_rx_rate_classifier.sv
// Combinational base-rate classifier: maps a measured frame time onto 48 kHz,
// 44.1 kHz or Unknown using a +/- FT_TOL window around each nominal.
//   frame_time  : measured frame length in clk cycles
//   base_rate_c : classified base rate (never a doubled rate)
module adat_rx_rate_classifier
  import adat_rx_adat_pkg::*;
#(
  parameter int unsigned FT_48K  = 2048,
  parameter int unsigned FT_44K1 = 2229,
  parameter int unsigned FT_TOL  = 32
) (
  input  logic [FT_W-1:0] frame_time,
  output SampleRate       base_rate_c
);

  // One extra bit so the difference is signed and can never wrap.
  localparam int unsigned DIFF_W = FT_W + 1;

  logic signed [DIFF_W-1:0] d48_c;
  logic signed [DIFF_W-1:0] d44_c;
  logic signed [DIFF_W-1:0] a48_c;
  logic signed [DIFF_W-1:0] a44_c;

  always_comb begin
    d48_c = $signed({1'b0, frame_time}) - $signed(DIFF_W'(FT_48K));
    d44_c = $signed({1'b0, frame_time}) - $signed(DIFF_W'(FT_44K1));
    a48_c = d48_c[DIFF_W-1] ? -d48_c : d48_c;
    a44_c = d44_c[DIFF_W-1] ? -d44_c : d44_c;

    base_rate_c = Unknown;
    if (a48_c <= $signed(DIFF_W'(FT_TOL))) begin
      base_rate_c = Rate48kHz;
    end else if (a44_c <= $signed(DIFF_W'(FT_TOL))) begin
      base_rate_c = Rate44_1kHz;
    end
  end

endmodule

// File: rtl/adat_rx_lock_controller.sv
// ADAT receive lock/rate sequencer. Qualifies decoded frames, runs the
// UNLOCKED/ACQUIRE/LOCKED/HOLDOVER state machine with a frame watchdog, and
// registers the lock, rate, S/MUX2 and channel-count qualifiers.
//   i_clk, i_rst (async, active-low)
//   bus (slave) : frame info in, lock status out
module adat_rx_lock_controller
  import adat_rx_adat_pkg::*;
#(
  parameter int unsigned FT_48K      = 2048,
  parameter int unsigned FT_44K1     = 2229,
  parameter int unsigned FT_TOL      = 32,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned MISS_FRAMES = 3,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  adat_rx_lock_controller_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);

  LockState          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  SampleRate         ref_rate_q, ref_rate_d;
  logic              ref_smux_q, ref_smux_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              locked_q, locked_d;
  SampleRate         rate_q, rate_d;
  logic              smux_q, smux_d;
  logic [CH_W-1:0]   chan_q, chan_d;

  SampleRate         frame_rate_c;
  logic              frame_smux_c;
  logic              valid_frame_c;
  logic              rate_match_c;
  logic              match_c;
  logic              miss_evt_c;
  logic              unused_ub;

  adat_rx_rate_classifier #(
    .FT_48K  (FT_48K),
    .FT_44K1 (FT_44K1),
    .FT_TOL  (FT_TOL)
  ) u_classifier (
    .frame_time  (bus.i_frame_time),
    .base_rate_c (frame_rate_c)
  );

  assign frame_smux_c = bus.i_user_bits[UB_SMUX_BIT];
  assign unused_ub    = ^{bus.i_user_bits[3:2], bus.i_user_bits[0]};

  // Next-state, counters and next output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_rate_d = ref_rate_q;
    ref_smux_d = ref_smux_q;
    miss_d     = miss_q;
    wdog_d     = wdog_q + 1'b1;
    miss_evt_c = 1'b0;

    valid_frame_c = bus.i_frame_done & bus.i_sync & (frame_rate_c != Unknown);
    rate_match_c  = (frame_rate_c == ref_rate_q);
    match_c       = rate_match_c & (frame_smux_c == ref_smux_q);

    // A frame_done in the expiry cycle wins over the watchdog.
    if (bus.i_frame_done) begin
      wdog_d = '0;
    end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
      wdog_d     = '0;
      miss_evt_c = 1'b1;
    end

    case (state_q)
      UNLOCKED: begin
        if (valid_frame_c) begin
          state_d    = ACQUIRE;
          cnt_d      = CNT_W'(1);
          ref_rate_d = frame_rate_c;
          ref_smux_d = frame_smux_c;
        end
      end
      ACQUIRE: begin
        if (valid_frame_c) begin
          if (match_c) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(LOCK_FRAMES - 1)) begin
              state_d = LOCKED;
            end
          end else begin
            // Rate or S/MUX2 changed: this frame becomes the new reference.
            cnt_d      = CNT_W'(1);
            ref_rate_d = frame_rate_c;
            ref_smux_d = frame_smux_c;
          end
        end else if (bus.i_frame_done || miss_evt_c) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (valid_frame_c && match_c) begin
          state_d = LOCKED;
        end else if (valid_frame_c && rate_match_c) begin
          // Same rate, S/MUX2 flipped: reacquire in the new mode.
          state_d    = ACQUIRE;
          cnt_d      = CNT_W'(1);
          ref_smux_d = frame_smux_c;
        end else if (bus.i_frame_done || miss_evt_c) begin
          state_d = HOLDOVER;
          miss_d  = MISS_W'(1);
        end
      end
      HOLDOVER: begin
        if (valid_frame_c && match_c) begin
          state_d = LOCKED;
          miss_d  = '0;
        end else if (bus.i_frame_done || miss_evt_c) begin
          if (miss_q == MISS_W'(MISS_FRAMES)) begin
            state_d = UNLOCKED;
            miss_d  = '0;
            cnt_d   = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
        miss_d  = '0;
      end
    endcase

    // Qualifiers follow the next state so they change together with it.
    locked_d = (state_d == LOCKED) || (state_d == HOLDOVER);
    rate_d   = locked_d ? rate_for_mode(ref_rate_d, ref_smux_d) : Unknown;
    smux_d   = locked_d & ref_smux_d;
    chan_d   = locked_d ? (ref_smux_d ? CH_W'(4) : CH_W'(8)) : '0;
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= UNLOCKED;
      cnt_q      <= '0;
      ref_rate_q <= Unknown;
      ref_smux_q <= 1'b0;
      miss_q     <= '0;
      wdog_q     <= '0;
      locked_q   <= 1'b0;
      rate_q     <= Unknown;
      smux_q     <= 1'b0;
      chan_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_rate_q <= ref_rate_d;
      ref_smux_q <= ref_smux_d;
      miss_q     <= miss_d;
      wdog_q     <= wdog_d;
      locked_q   <= locked_d;
      rate_q     <= rate_d;
      smux_q     <= smux_d;
      chan_q     <= chan_d;
    end
  end

  assign bus.o_locked         = locked_q;
  assign bus.o_sample_rate    = rate_q;
  assign bus.o_smux           = smux_q;
  assign bus.o_valid_channels = chan_q;
  assign bus.o_state          = state_q;
  assign bus.o_miss_count     = miss_q;

endmodule

// File: tb/tb_adat_rx_lock_controller.sv
// Directed bench for adat_rx_lock_controller: lock acquisition, S/MUX2 rates,
// holdover, watchdog unlock, rate restart/reject and async reset.
module tb_adat_rx_lock_controller;
  import adat_rx_adat_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  adat_rx_lock_controller_if bus ();

  adat_rx_lock_controller dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_frame_done = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  // One frame_done pulse, then gap idle cycles; entered and left at posedge+1.
  task automatic send_frame(input logic [11:0] ft, input logic s, input logic [3:0] ub,
                            input int gap);
    bus.i_frame_time = ft;
    bus.i_sync       = s;
    bus.i_user_bits  = ub;
    bus.i_frame_done = 1'b1;
    @(posedge clk);
    #1;
    bus.i_frame_done = 1'b0;
    if (gap > 0) cycles(gap);
  endtask

  task automatic check_status(input string tag, input LockState st, input logic lk,
                              input SampleRate rt, input int ch, input int miss);
    check({tag, "_state"},  int'(bus.o_state),          int'(st));
    check({tag, "_locked"}, int'(bus.o_locked),         int'(lk));
    check({tag, "_rate"},   int'(bus.o_sample_rate),    int'(rt));
    check({tag, "_chan"},   int'(bus.o_valid_channels), ch);
    check({tag, "_miss"},   int'(bus.o_miss_count),     miss);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n            = 1'b0;
    bus.i_frame_time = '0;
    bus.i_frame_done = 1'b0;
    bus.i_sync       = 1'b0;
    bus.i_user_bits  = '0;
    cycles(3);

    // 1: reset values, then lock at 48k
    check_status("rst", UNLOCKED, 1'b0, Unknown, 0, 0);
    check("rst_smux", int'(bus.o_smux), 0);
    rst_n = 1'b1;
    cycles(1);
    send_frame(12'd2048, 1'b1, 4'b0000, 2);
    check("t1_acq", int'(bus.o_state), int'(ACQUIRE));
    send_frame(12'd2048, 1'b1, 4'b0000, 2);
    send_frame(12'd2048, 1'b1, 4'b0000, 2);
    check("t1_3fr_locked", int'(bus.o_locked), 0);
    send_frame(12'd2048, 1'b1, 4'b0000, 0);
    check_status("t1_lock", LOCKED, 1'b1, Rate48kHz, 8, 0);
    check("t1_smux", int'(bus.o_smux), 0);

    // 2: S/MUX2 doubling at 48k and 44k1
    do_reset();
    repeat (4) send_frame(12'd2048, 1'b1, 4'b0010, 2);
    check_status("t2_96k", LOCKED, 1'b1, Rate96kHz, 4, 0);
    check("t2_96k_smux", int'(bus.o_smux), 1);
    do_reset();
    repeat (4) send_frame(12'd2229, 1'b1, 4'b0010, 2);
    check_status("t2_88k2", LOCKED, 1'b1, Rate88_2kHz, 4, 0);

    // 3: holdover on missing sync, recovery
    do_reset();
    repeat (4) send_frame(12'd2048, 1'b1, 4'b0000, 2);
    send_frame(12'd2048, 1'b0, 4'b0000, 2);
    check_status("t3_ho1", HOLDOVER, 1'b1, Rate48kHz, 8, 1);
    send_frame(12'd2048, 1'b0, 4'b0000, 2);
    check_status("t3_ho2", HOLDOVER, 1'b1, Rate48kHz, 8, 2);
    send_frame(12'd2048, 1'b1, 4'b0000, 2);
    check_status("t3_relock", LOCKED, 1'b1, Rate48kHz, 8, 0);

    // 4: watchdog; last pulse edge E0, now at E2; misses land at E4096*k
    send_frame(12'd2048, 1'b1, 4'b0000, 2);
    cycles(4093);
    check("t4_e4095", int'(bus.o_state), int'(LOCKED));
    cycles(1);
    check_status("t4_e4096", HOLDOVER, 1'b1, Rate48kHz, 8, 1);
    cycles(12287);
    check_status("t4_e16383", HOLDOVER, 1'b1, Rate48kHz, 8, 3);
    cycles(1);
    check_status("t4_unlock", UNLOCKED, 1'b0, Unknown, 0, 0);

    // 5: rate change restarts acquisition; window edges; out-of-window rejects
    do_reset();
    send_frame(12'd2080, 1'b1, 4'b0000, 2);
    send_frame(12'd2016, 1'b1, 4'b0000, 2);
    send_frame(12'd2229, 1'b1, 4'b0000, 2);
    check("t5_restart_acq", int'(bus.o_state), int'(ACQUIRE));
    send_frame(12'd2197, 1'b1, 4'b0000, 2);
    send_frame(12'd2261, 1'b1, 4'b0000, 2);
    check("t5_3x44_locked", int'(bus.o_locked), 0);
    send_frame(12'd2229, 1'b1, 4'b0000, 2);
    check_status("t5_44k1", LOCKED, 1'b1, Rate44_1kHz, 8, 0);
    do_reset();
    send_frame(12'd2048, 1'b1, 4'b0000, 2);
    send_frame(12'd2300, 1'b1, 4'b0000, 2);
    check("t5_2300_unlock", int'(bus.o_state), int'(UNLOCKED));
    send_frame(12'd2048, 1'b1, 4'b0000, 2);
    send_frame(12'd2081, 1'b1, 4'b0000, 2);
    check("t5_2081_unlock", int'(bus.o_state), int'(UNLOCKED));

    // 6: S/MUX2 toggle while locked, then async reset mid-frame
    do_reset();
    repeat (4) send_frame(12'd2048, 1'b1, 4'b0000, 2);
    send_frame(12'd2048, 1'b1, 4'b0010, 2);
    check_status("t6_toggle", ACQUIRE, 1'b0, Unknown, 0, 0);
    send_frame(12'd2048, 1'b1, 4'b0010, 2);
    send_frame(12'd2048, 1'b1, 4'b0010, 2);
    check("t6_3fr_locked", int'(bus.o_locked), 0);
    send_frame(12'd2048, 1'b1, 4'b0010, 2);
    check_status("t6_relock", LOCKED, 1'b1, Rate96kHz, 4, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_status("t6_async", UNLOCKED, 1'b0, Unknown, 0, 0);
    check("t6_async_smux", int'(bus.o_smux), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("t6_after_rst", int'(bus.o_state), int'(UNLOCKED));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
